ula_mc: RTL and testbench
=========================

Name: ula_mc

Overview:
- WIDTH-bit multi-cycle ALU for the MIPS datapath; generalisation of the 1-bit ULA slice to a full word.
- Operations: AND, OR, NOR, XOR, ADD, SUB and SLT, each with a registered result, plus an iterative shift-add multiply that writes HI/LO.
- Sits in the EX stage. The control FSM issues a start, then waits for done.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- CNTW, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only when busy=0.
- mult  input  1  1 = multiply (ULAcontrole ignored); 0 = ALU op.
- ULAcontrole  input  3  op select: 000 AND, 001 OR, 010 ADD, 011 NOR, 100 reserved, 101 XOR, 110 SUB, 111 SLT.
- a  input  WIDTH  operand A; sampled at accept.
- b  input  WIDTH  operand B; sampled at accept.
- ULAsaida  output  WIDTH  registered ALU result.
- zero  output  1  registered, (ULAsaida == 0).
- cout  output  1  registered carry out of ADD/SUB (SUB: 1 = no borrow).
- overflow  output  1  registered two's-complement overflow of ADD/SUB.
- hi  output  WIDTH  upper product half.
- lo  output  WIDTH  lower product half.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse: result valid.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0: ULAsaida, zero, cout, overflow, hi, lo, busy, done.
  - FSM goes to IDLE and the counter clears.
  - A reset during a multiply aborts it; hi/lo read 0.
- Accept: start=1 and busy=0 at rising edge N. start while busy=1 is ignored (no queueing, no error).
- ALU path (mult=0), latency 1:
  - At edge N, ULAsaida, zero, cout and overflow update.
  - done=1 for the single cycle after edge N. busy stays 0.
  - Back-to-back starts on consecutive cycles are allowed; done stays high continuously.
- Arithmetic:
  - ADD: sum = a + b, truncated to WIDTH.
  - SUB: sum = a + ~b + 1.
  - cout: bit WIDTH of the extended sum.
  - overflow = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]), where b' = b (ADD) or ~b (SUB).
  - SLT: ULAsaida = {WIDTH-1 zeros, sum_sub[MSB] ^ overflow_sub}, i.e. a correct signed compare; cout/overflow reflect the internal SUB.
  - Logic ops: cout=0, overflow=0.
  - Op 100: ULAsaida=0, zero=1, cout=0, overflow=0.
- Multiply path (mult=1):
  - FSM: IDLE -> MUL -> IDLE.
  - At edge N: latch a into the multiplicand and b into the multiplier, clear the accumulator, counter=0, busy=1.
  - Edges N+1..N+WIDTH: one shift-add iteration per edge.
  - At edge N+WIDTH: {hi,lo} = 2*WIDTH-bit product, busy=0, done=1 for one cycle.
  - Total latency is WIDTH cycles from accept.
  - ULAsaida, zero, cout and overflow hold their prior values during and after a multiply.
  - hi/lo change only at completion (no intermediate values visible).
- Boundaries:
  - Counter terminates exactly at WIDTH-1 (no wrap).
  - a=0 or b=0 still takes the full WIDTH cycles.
  - start on the cycle busy falls is accepted, because busy=0 at that edge is the registered value after the update.
  - done and start in the same cycle: the new op is accepted normally.

Optional Feature:
- Macro: ULA_SIGNED_MULT_EN.
- Defined:
  - Multiply treats a and b as two's complement.
  - Operands are converted to magnitude at accept; the product is negated at completion if a[MSB]^b[MSB].
  - Latency is unchanged (WIDTH cycles).
  - The most-negative operand is handled correctly, e.g. WIDTH=32: 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Undefined: multiply is unsigned only. No extra logic.

Test Plan:
- Reset mid-multiply: start mult a=7, b=9, assert reset at cycle 3 -> next cycle all outputs 0, busy=0; no done afterwards.
- ADD overflow (WIDTH=32): a=0x7FFFFFFF, b=1, op 010 -> one cycle later ULAsaida=0x80000000, overflow=1, cout=0, zero=0, done=1.
- SUB/SLT: a=5, b=5, op 110 -> ULAsaida=0, zero=1, cout=1. Then a=0x80000000, b=1, op 111 -> ULAsaida=1.
- Logic and reserved: a=0xF0F0F0F0, b=0xFF00FF00, ops 000/001/011/101 -> 0xF000F000, 0xFFF0FFF0, 0x000F000F, 0x0FF00FF0. Op 100 -> 0, zero=1.
- Multiply unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, mult=1 -> busy for 32 cycles, done at cycle 32, hi=0xFFFFFFFE, lo=0x00000001. A start pulsed at cycle 10 is ignored.
- Signed (with ULA_SIGNED_MULT_EN): a=-3 (0xFFFFFFFD), b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4. Without the macro -> hi=0x00000003, lo=0xFFFFFFF4.

Source files
------------

// File: rtl/ula_mc.sv
// Multi-cycle WIDTH-bit ALU for the MIPS EX stage: single-cycle logic/arith ops plus a
// WIDTH-cycle shift-add multiply into hi/lo. Define ULA_SIGNED_MULT_EN for a two's-complement multiply.
module ula_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mult,
  input  logic [2:0]       ULAcontrole,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ULAsaida,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [CNTW-1:0]    cnt_r;
  logic [WIDTH-1:0]   mcand_r, mplier_r, acc_r;
  logic [WIDTH-1:0]   saida_r, hi_r, lo_r;
  logic               zero_r, cout_r, ovf_r, busy_r, done_r;

  logic               accept_s, cnt_last_s, sub_s, ovf_add_s;
  logic [WIDTH-1:0]   bop_s, res_s, opa_s, opb_s;
  logic [WIDTH:0]     ext_s, add_s;
  logic [2*WIDTH-1:0] prod_s, final_s;
  logic               res_cout_s, res_ovf_s;

`ifdef ULA_SIGNED_MULT_EN
  logic               neg_r;
`endif

  assign accept_s   = start & ~busy_r;
  assign cnt_last_s = (cnt_r == CNTW'(WIDTH - 1));

  // Shared adder for ADD/SUB/SLT; SUB and SLT add ~b with carry-in 1.
  always_comb begin
    sub_s     = ULAcontrole[2] & ULAcontrole[1];
    bop_s     = sub_s ? ~b : b;
    ext_s     = {1'b0, a} + {1'b0, bop_s} + {{WIDTH{1'b0}}, sub_s};
    ovf_add_s = (a[WIDTH-1] == bop_s[WIDTH-1]) & (ext_s[WIDTH-1] != a[WIDTH-1]);
  end

  // Result selection by operation code.
  always_comb begin
    res_s      = {WIDTH{1'b0}};
    res_cout_s = 1'b0;
    res_ovf_s  = 1'b0;
    case (ULAcontrole)
      3'b000: res_s = a & b;
      3'b001: res_s = a | b;
      3'b011: res_s = ~(a | b);
      3'b101: res_s = a ^ b;
      3'b010, 3'b110: begin
        res_s      = ext_s[WIDTH-1:0];
        res_cout_s = ext_s[WIDTH];
        res_ovf_s  = ovf_add_s;
      end
      3'b111: begin
        res_s      = {{(WIDTH-1){1'b0}}, ext_s[WIDTH-1] ^ ovf_add_s};
        res_cout_s = ext_s[WIDTH];
        res_ovf_s  = ovf_add_s;
      end
      default: begin
        res_s      = {WIDTH{1'b0}};
        res_cout_s = 1'b0;
        res_ovf_s  = 1'b0;
      end
    endcase
  end

  // One shift-add step: {acc, multiplier} shifts right with the conditional add folded in.
  always_comb begin
    add_s  = {1'b0, acc_r} + (mplier_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    prod_s = {add_s, mplier_r[WIDTH-1:1]};
`ifdef ULA_SIGNED_MULT_EN
    opa_s   = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    opb_s   = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    final_s = neg_r ? (~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;
`else
    opa_s   = a;
    opb_s   = b;
    final_s = prod_s;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && mult) state_nxt_s = MUL;
        else                  state_nxt_s = IDLE;
      end
      MUL: begin
        if (cnt_last_s) state_nxt_s = IDLE;
        else            state_nxt_s = MUL;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers: ALU results, multiplier iteration and handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= {CNTW{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      saida_r  <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef ULA_SIGNED_MULT_EN
      neg_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (accept_s && mult) begin
        mcand_r  <= opa_s;
        mplier_r <= opb_s;
        acc_r    <= {WIDTH{1'b0}};
        cnt_r    <= {CNTW{1'b0}};
        busy_r   <= 1'b1;
`ifdef ULA_SIGNED_MULT_EN
        neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
      end else if (accept_s) begin
        saida_r <= res_s;
        zero_r  <= (res_s == {WIDTH{1'b0}});
        cout_r  <= res_cout_s;
        ovf_r   <= res_ovf_s;
        done_r  <= 1'b1;
      end else if (state_r == MUL) begin
        acc_r    <= prod_s[2*WIDTH-1:WIDTH];
        mplier_r <= prod_s[WIDTH-1:0];
        if (cnt_last_s) begin
          hi_r   <= final_s[2*WIDTH-1:WIDTH];
          lo_r   <= final_s[WIDTH-1:0];
          cnt_r  <= {CNTW{1'b0}};
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          cnt_r  <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign ULAsaida = saida_r;
  assign zero     = zero_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_ula_mc.sv
// Directed self-checking bench for ula_mc (WIDTH=32); expected multiply results follow ULA_SIGNED_MULT_EN.
module tb_ula_mc;

  logic        clk = 1'b0;
  logic        reset, start, mult;
  logic [2:0]  ULAcontrole;
  logic [31:0] a, b, ULAsaida, hi, lo;
  logic        zero, cout, overflow, busy, done;

  int checks = 0;
  int errors = 0;

  ula_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mult(mult), .ULAcontrole(ULAcontrole),
    .a(a), .b(b), .ULAsaida(ULAsaida), .zero(zero), .cout(cout), .overflow(overflow),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one ALU op; start is left high so calls chain back-to-back.
  task automatic alu(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    mult = 1'b0; ULAcontrole = op; a = va; b = vb; start = 1'b1;
    tick();
  endtask

  // Accept a multiply, then count edges to done (99 on timeout); optional ignored start at edge poke.
  task automatic mul_run(input logic [31:0] va, input logic [31:0] vb, input int poke,
                         input logic [31:0] hold_hi, output int n);
    mult = 1'b1; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    check("mul_busy_at_accept", {63'd0, busy}, 64'd1);
    n = 99;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke) begin a = 32'd2; b = 32'd3; start = 1'b1; end
      tick();
      start = 1'b0;
      if (k == 20) begin
        check("mul_busy_mid", {63'd0, busy}, 64'd1);
        check("mul_hi_held_mid", {32'd0, hi}, {32'd0, hold_hi});
      end
      if (done) begin n = k; break; end
    end
  endtask

  int n, dones;
  logic [63:0] exp_sm;

  initial begin
    reset = 1'b1; start = 1'b0; mult = 1'b0; ULAcontrole = 3'b000; a = 32'd0; b = 32'd0;
    tick(); tick();
    check("rst_saida", {32'd0, ULAsaida}, 64'd0);
    check("rst_flags", {59'd0, zero, cout, overflow, busy, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    alu(3'b010, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf_saida", {32'd0, ULAsaida}, 64'h8000_0000);
    check("add_ovf_flags", {60'd0, zero, cout, overflow, done}, 64'b0011);
    alu(3'b110, 32'd5, 32'd5);
    check("sub_eq", {28'd0, zero, cout, overflow, done, ULAsaida}, {28'd0, 4'b1101, 32'd0});
    alu(3'b111, 32'h8000_0000, 32'd1);
    check("slt_neg_lt", {28'd0, zero, cout, overflow, done, ULAsaida}, {28'd0, 4'b0111, 32'd1});
    alu(3'b111, 32'd1, 32'h8000_0000);
    check("slt_pos_ge", {32'd0, ULAsaida}, 64'd0);
    alu(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("and", {28'd0, zero, cout, overflow, done, ULAsaida}, {28'd0, 4'b0001, 32'hF000_F000});
    alu(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("or", {32'd0, ULAsaida}, 64'hFFF0_FFF0);
    alu(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("nor", {32'd0, ULAsaida}, 64'h000F_000F);
    alu(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("xor", {32'd0, ULAsaida}, 64'h0FF0_0FF0);
    alu(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("reserved", {28'd0, zero, cout, overflow, done, ULAsaida}, {28'd0, 4'b1001, 32'd0});
    alu(3'b010, 32'd2, 32'd3);
    check("add_small", {28'd0, zero, cout, overflow, done, ULAsaida}, {28'd0, 4'b0001, 32'd5});
    start = 1'b0;
    tick();
    check("done_drops", {63'd0, done}, 64'd0);

    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 32'd0, n);
    check("mul_ff_latency", n, 64'd32);
    check("mul_ff_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("mul_ff_busy_done", {62'd0, busy, done}, 64'b01);
    check("mul_alu_held", {28'd0, zero, cout, overflow, 1'b0, ULAsaida}, {28'd0, 4'b0000, 32'd5});

`ifdef ULA_SIGNED_MULT_EN
    exp_sm = 64'hFFFF_FFFF_FFFF_FFF4;
`else
    exp_sm = 64'h0000_0003_FFFF_FFF4;
`endif
    // Issued while done is still high: must be accepted.
    mul_run(32'hFFFF_FFFD, 32'd4, 0, 32'hFFFF_FFFE, n);
    check("mul_neg_latency", n, 64'd32);
    check("mul_neg_prod", {hi, lo}, exp_sm);

    mul_run(32'h8000_0000, 32'h8000_0000, 0, exp_sm[63:32], n);
    check("mul_minneg_prod", {hi, lo}, 64'h4000_0000_0000_0000);
    mul_run(32'd0, 32'd5, 0, 32'h4000_0000, n);
    check("mul_zero_latency", n, 64'd32);
    check("mul_zero_prod", {hi, lo}, 64'd0);
    tick();

    mult = 1'b1; a = 32'd7; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_flags", {59'd0, zero, cout, overflow, busy, done}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_saida", {32'd0, ULAsaida}, 64'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) dones++;
    end
    check("rst_mid_no_done", dones, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
